// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: forwarding, load-use/branch hazards, memory-wait freeze with timeout, perf counters
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [4:0]       idex_rs1_addr_i,
  input  logic [4:0]       idex_rs2_addr_i,
  input  logic [4:0]       idex_rd_addr_i,
  input  logic             idex_mem_read_i,
  input  logic             idex_valid_i,
  input  logic [4:0]       exmem_rd_addr_i,
  input  logic             exmem_reg_write_i,
  input  logic             exmem_valid_i,
  input  logic [4:0]       memwb_rd_addr_i,
  input  logic             memwb_reg_write_i,
  input  logic             memwb_valid_i,
  input  logic             branch_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_stall_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             pipe_freeze_o,
  output logic [1:0]       forward_a_o,
  output logic [1:0]       forward_b_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_count_o,
  output logic [CNT_W-1:0] flush_count_o
);
  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic {S_RUN, S_WAIT} state_t;
  state_t           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;
  logic             ex_a, ex_b, wb_a, wb_b;
  logic             load_use, start_wait, freeze, flush_ev;

  // EX operand selects: youngest producer (EX/MEM) wins, x0 never forwarded
  always_comb begin
    ex_a = exmem_valid_i & exmem_reg_write_i & (exmem_rd_addr_i != 5'd0) & (exmem_rd_addr_i == idex_rs1_addr_i);
    ex_b = exmem_valid_i & exmem_reg_write_i & (exmem_rd_addr_i != 5'd0) & (exmem_rd_addr_i == idex_rs2_addr_i);
    wb_a = memwb_valid_i & memwb_reg_write_i & (memwb_rd_addr_i != 5'd0) & (memwb_rd_addr_i == idex_rs1_addr_i);
    wb_b = memwb_valid_i & memwb_reg_write_i & (memwb_rd_addr_i != 5'd0) & (memwb_rd_addr_i == idex_rs2_addr_i);
    forward_a_o = !reset_n_i ? 2'b00 : ex_a ? 2'b10 : wb_a ? 2'b01 : 2'b00;
    forward_b_o = !reset_n_i ? 2'b00 : ex_b ? 2'b10 : wb_b ? 2'b01 : 2'b00;
  end

  // Stall/flush/freeze: freeze beats flushes, flushes beat load-use; the timeout cycle flushes instead of re-waiting
  always_comb begin
    load_use   = idex_valid_i & idex_mem_read_i & (idex_rd_addr_i != 5'd0) &
                 ((id_use_rs1_i & (id_rs1_addr_i == idex_rd_addr_i)) |
                  (id_use_rs2_i & (id_rs2_addr_i == idex_rd_addr_i)));
    start_wait = (state_q == S_RUN) & dmem_req_i & ~dmem_ready_i & ~mem_timeout_q;
    freeze     = start_wait | ((state_q == S_WAIT) & ~dmem_ready_i);
    flush_ev   = branch_taken_i | mem_timeout_q;
    pipe_freeze_o = reset_n_i & freeze;
    pc_stall_o    = reset_n_i & (freeze | (~flush_ev & load_use));
    ifid_stall_o  = reset_n_i & (freeze | (~flush_ev & load_use));
    ifid_flush_o  = reset_n_i & ~freeze & flush_ev;
    idex_flush_o  = reset_n_i & ~freeze & (flush_ev | load_use);
    mem_timeout_o = reset_n_i & mem_timeout_q;
  end

  // Memory-wait FSM: count not-ready cycles, abandon the access after MEM_TIMEOUT of them
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = 1'b0;
    if (state_q == S_RUN) begin
      if (start_wait) begin
        state_d    = S_WAIT;
        wait_cnt_d = WCW'(1);
      end
    end else if (dmem_ready_i) begin
      state_d    = S_RUN;
      wait_cnt_d = '0;
    end else if (wait_cnt_q == WCW'(MEM_TIMEOUT)) begin
      state_d       = S_RUN;
      wait_cnt_d    = '0;
      mem_timeout_d = 1'b1;
    end else begin
      wait_cnt_d = wait_cnt_q + WCW'(1);
    end
  end

  // Wrapping performance counters
  always_comb begin
    stall_count_d = stall_count_q + CNT_W'(pc_stall_o);
    flush_count_d = flush_count_q + CNT_W'((branch_taken_i & ~freeze) | mem_timeout_q);
  end

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q       <= S_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count_o = stall_count_q;
  assign flush_count_o = flush_count_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scoreboard bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4)
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  logic [4:0] id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
  logic id_use_rs1, id_use_rs2, idex_mem_read, idex_valid;
  logic exmem_rw, exmem_v, memwb_rw, memwb_v, branch, dmem_req, dmem_ready;
  logic pc_stall, ifid_stall, ifid_flush, idex_flush, pipe_freeze, mem_timeout;
  logic [1:0] forward_a, forward_b;
  logic [3:0] stall_count, flush_count;

  typedef struct packed {
    logic [5:0] ctl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;
  exp_t  q[$];
  string nq[$];
  exp_t  e;
  string en;
  int    checks = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .id_rs1_addr_i(id_rs1), .id_rs2_addr_i(id_rs2),
    .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
    .idex_rs1_addr_i(idex_rs1), .idex_rs2_addr_i(idex_rs2), .idex_rd_addr_i(idex_rd),
    .idex_mem_read_i(idex_mem_read), .idex_valid_i(idex_valid),
    .exmem_rd_addr_i(exmem_rd), .exmem_reg_write_i(exmem_rw), .exmem_valid_i(exmem_v),
    .memwb_rd_addr_i(memwb_rd), .memwb_reg_write_i(memwb_rw), .memwb_valid_i(memwb_v),
    .branch_taken_i(branch), .dmem_req_i(dmem_req), .dmem_ready_i(dmem_ready),
    .pc_stall_o(pc_stall), .ifid_stall_o(ifid_stall), .ifid_flush_o(ifid_flush),
    .idex_flush_o(idex_flush), .pipe_freeze_o(pipe_freeze),
    .forward_a_o(forward_a), .forward_b_o(forward_b), .mem_timeout_o(mem_timeout),
    .stall_count_o(stall_count), .flush_count_o(flush_count)
  );

  task automatic cmp(input string n, input string f, input int a, input int x);
    checks++;
    if (a != x) begin
      failures++;
      $display("FAIL %s.%s actual=%0h expected=%0h", n, f, a, x);
    end
  endtask

  // Monitor: every cycle the DUT presents a response; pop the matching expectation and compare
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e  = q.pop_front();
      en = nq.pop_front();
      cmp(en, "ctl{pcs,ifs,iff,idf,frz,to}", int'({pc_stall, ifid_stall, ifid_flush, idex_flush, pipe_freeze, mem_timeout}), int'(e.ctl));
      cmp(en, "forward_a", int'(forward_a), int'(e.fa));
      cmp(en, "forward_b", int'(forward_b), int'(e.fb));
      cmp(en, "stall_count", int'(stall_count), int'(e.sc));
      cmp(en, "flush_count", int'(flush_count), int'(e.fc));
    end
  end

  task automatic clr();
    {id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd} = '0;
    {id_use_rs1, id_use_rs2, idex_mem_read, idex_valid} = '0;
    {exmem_rw, exmem_v, memwb_rw, memwb_v, branch, dmem_req, dmem_ready} = '0;
  endtask

  task automatic vec(input string n, input logic [5:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                     input logic [3:0] sc, input logic [3:0] fc);
    q.push_back('{ctl: ctl, fa: fa, fb: fb, sc: sc, fc: fc});
    nq.push_back(n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exmem_rd = 5; exmem_rw = 1; exmem_v = 1; idex_rs1 = 5; branch = 1; dmem_req = 1;
    vec("reset", 6'b000000, 2'b00, 2'b00, 0, 0);
    reset_n = 1'b1;
    clr();
    // forwarding priority and x0
    exmem_rd = 5; exmem_rw = 1; exmem_v = 1; memwb_rd = 5; memwb_rw = 1; memwb_v = 1;
    idex_rs1 = 5; idex_rs2 = 5;
    vec("fwd_exmem", 6'b000000, 2'b10, 2'b10, 0, 0);
    exmem_v = 0;
    vec("fwd_memwb", 6'b000000, 2'b01, 2'b01, 0, 0);
    exmem_v = 1; exmem_rd = 0; memwb_rd = 0; idex_rs1 = 0; idex_rs2 = 0;
    vec("fwd_x0", 6'b000000, 2'b00, 2'b00, 0, 0);
    exmem_rd = 3; memwb_rd = 4; idex_rs1 = 4; idex_rs2 = 3;
    vec("fwd_mixed", 6'b000000, 2'b01, 2'b10, 0, 0);
    clr();
    // load-use
    idex_valid = 1; idex_mem_read = 1; idex_rd = 7; id_rs2 = 7; id_use_rs2 = 1;
    vec("load_use", 6'b110100, 2'b00, 2'b00, 0, 0);
    idex_valid = 0;
    vec("bubble", 6'b000000, 2'b00, 2'b00, 1, 0);
    idex_valid = 1; id_use_rs2 = 0;
    vec("no_use", 6'b000000, 2'b00, 2'b00, 1, 0);
    id_rs1 = 7; id_use_rs1 = 1;
    vec("lu_rs1", 6'b110100, 2'b00, 2'b00, 1, 0);
    idex_rd = 0; id_rs1 = 0;
    vec("lu_x0", 6'b000000, 2'b00, 2'b00, 2, 0);
    // branch overrides load-use
    idex_rd = 7; id_rs1 = 7; branch = 1;
    vec("br_lu", 6'b001100, 2'b00, 2'b00, 2, 0);
    clr();
    vec("after_br", 6'b000000, 2'b00, 2'b00, 2, 1);
    // memory wait, branch held throughout
    dmem_req = 1; branch = 1;
    vec("mw_req", 6'b110010, 2'b00, 2'b00, 2, 1);
    vec("mw_w1", 6'b110010, 2'b00, 2'b00, 3, 1);
    vec("mw_w2", 6'b110010, 2'b00, 2'b00, 4, 1);
    dmem_ready = 1;
    vec("mw_ready", 6'b001100, 2'b00, 2'b00, 5, 1);
    clr();
    vec("mw_after", 6'b000000, 2'b00, 2'b00, 5, 2);
    // timeout
    dmem_req = 1;
    vec("to_req", 6'b110010, 2'b00, 2'b00, 5, 2);
    vec("to_w1", 6'b110010, 2'b00, 2'b00, 6, 2);
    vec("to_w2", 6'b110010, 2'b00, 2'b00, 7, 2);
    vec("to_w3", 6'b110010, 2'b00, 2'b00, 8, 2);
    vec("to_w4", 6'b110010, 2'b00, 2'b00, 9, 2);
    vec("to_pulse", 6'b001101, 2'b00, 2'b00, 10, 2);
    clr();
    vec("to_after", 6'b000000, 2'b00, 2'b00, 10, 3);
    // reset during WAIT
    dmem_req = 1;
    vec("rw_req", 6'b110010, 2'b00, 2'b00, 10, 3);
    vec("rw_w1", 6'b110010, 2'b00, 2'b00, 11, 3);
    reset_n = 0;
    vec("rw_rst", 6'b000000, 2'b00, 2'b00, 12, 3);
    reset_n = 1; dmem_req = 0; dmem_ready = 1;
    vec("rw_post", 6'b000000, 2'b00, 2'b00, 0, 0);
    dmem_req = 1; dmem_ready = 0;
    vec("rw_fresh", 6'b110010, 2'b00, 2'b00, 0, 0);
    vec("rw_w1b", 6'b110010, 2'b00, 2'b00, 1, 0);
    vec("rw_w2b", 6'b110010, 2'b00, 2'b00, 2, 0);
    vec("rw_w3b", 6'b110010, 2'b00, 2'b00, 3, 0);
    vec("rw_w4b", 6'b110010, 2'b00, 2'b00, 4, 0);
    vec("rw_pulse", 6'b001101, 2'b00, 2'b00, 5, 0);
    clr();
    reset_n = 0;
    vec("wrap_rst", 6'b000000, 2'b00, 2'b00, 5, 1);
    // 17 load-use stalls wrap a 4-bit counter to 1
    reset_n = 1;
    idex_valid = 1; idex_mem_read = 1; idex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
    for (int i = 0; i < 17; i++) vec("wrap_lu", 6'b110100, 2'b00, 2'b00, 4'(i), 0);
    clr();
    vec("wrap_end", 6'b000000, 2'b00, 2'b00, 1, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
